// File: rtl/hdmi_i2c_target_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdmi_i2c_target_pkg                                                        |
// | Shared state type, ACK/NACK levels and filter helper for the I2C target.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hdmi_i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    SUB      = 4'd3,
    SUB_ACK  = 4'd4,
    WDAT     = 4'd5,
    WDAT_ACK = 4'd6,
    RDAT     = 4'd7,
    RDAT_ACK = 4'd8,
    IGNORE   = 4'd9
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_i2c_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdmi_i2c_line_sync                                                         |
// | SCL/SDA synchroniser with optional majority filter (HDMI_I2C_TARGET_GLITCH_EN)|
// | plus edge, START and STOP detection. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
module hdmi_i2c_line_sync
  import hdmi_i2c_target_pkg::*;
(
  input  logic iCLK,
  input  logic iRST_N,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl;
  logic       w_sda;

  // Reset to the idle-bus level so no edge is seen when reset is released.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef HDMI_I2C_TARGET_GLITCH_EN
  logic [2:0] r_scl_hist;
  logic [2:0] r_sda_hist;
  logic       r_scl_f;
  logic       r_sda_f;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
      r_scl_f    <= maj3(r_scl_hist);
      r_sda_f    <= maj3(r_sda_hist);
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign scl       = w_scl;
  assign sda       = w_sda;
  assign scl_rise  =  w_scl & ~r_scl_d;
  assign scl_fall  = ~w_scl &  r_scl_d;
  // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
  assign start_det = w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign stop_det  = w_scl & r_scl_d & ~r_sda_d &  w_sda;

endmodule
`default_nettype wire

// File: rtl/hdmi_i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdmi_i2c_target                                                            |
// | I2C target with 256x8 register map, burst read/write, host peek port.      |
// | Option: HDMI_I2C_TARGET_GLITCH_EN adds line majority filter. Revision: 1.0 |
// +----------------------------------------------------------------------------+
module hdmi_i2c_target
  import hdmi_i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       busy
);

  localparam int                c_to_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYC);

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  hdmi_i2c_line_sync u_line_sync (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .scl_in    (I2C_SCL),
    .sda_in    (I2C_SDA),
    .scl       (w_scl),
    .sda       (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  i2c_tgt_state_t    r_state, w_state_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_ack_ph, w_ack_ph_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic [7:0]        r_ptr, w_ptr_nxt;
  logic              r_rw, w_rw_nxt;
  logic              w_wr_en;
  logic [c_to_w-1:0] r_to_cnt;
  logic              w_timeout;
  logic [7:0]        r_regs [256];
  logic [7:0]        w_byte;
  logic [7:0]        w_ptr_inc;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_ptr_inc = r_ptr + 8'd1;
  assign w_timeout = (r_to_cnt == c_to_max);
  assign busy      = (r_state != IDLE);
  assign I2C_SDA   = r_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_to_cnt <= '0;
    end else if (w_scl_rise || w_scl_fall || (r_state == IDLE)) begin
      r_to_cnt <= '0;
    end else if (!w_scl && !w_timeout) begin
      r_to_cnt <= r_to_cnt + c_to_w'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ack_ph_nxt  = r_ack_ph;
    w_sda_oe_nxt  = r_sda_oe;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_wr_en       = 1'b0;
    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_bit_cnt_nxt = 3'd0;
      w_ack_ph_nxt  = 1'b0;
      w_sda_oe_nxt  = 1'b0;
    end else if (w_timeout) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ADDR, SUB, WDAT: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ack_ph_nxt = 1'b0;
              if (r_state == ADDR) begin
                w_rw_nxt    = w_byte[0];
                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
              end else if (r_state == SUB) begin
                w_ptr_nxt   = w_byte;
                w_state_nxt = SUB_ACK;
              end else begin
                w_wr_en     = 1'b1;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = WDAT_ACK;
              end
            end
          end
        end
        // First SCL fall asserts ACK, second releases it and moves on.
        ADDR_ACK, SUB_ACK, WDAT_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_ph) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_ph_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_ack_ph_nxt  = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              if ((r_state == ADDR_ACK) && r_rw) begin
                w_shift_nxt  = r_regs[r_ptr];
                w_sda_oe_nxt = ~r_regs[r_ptr][7];
                w_state_nxt  = RDAT;
              end else if (r_state == ADDR_ACK) begin
                w_state_nxt = SUB;
              end else begin
                w_state_nxt = WDAT;
              end
            end
          end
        end
        // A fall with no rise yet in the byte presents the MSB without shifting.
        RDAT: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd0) begin
              w_sda_oe_nxt = ~r_shift[7];
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end else if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_ack_ph_nxt = 1'b0;
              w_state_nxt  = RDAT_ACK;
            end
          end
        end
        RDAT_ACK: begin
          if (w_scl_fall && !r_ack_ph) begin
            w_sda_oe_nxt = 1'b0;
            w_ack_ph_nxt = 1'b1;
          end else if (w_scl_rise && r_ack_ph) begin
            w_ack_ph_nxt = 1'b0;
            if (w_sda == I2C_ACK) begin
              w_ptr_nxt     = w_ptr_inc;
              w_shift_nxt   = r_regs[w_ptr_inc];
              w_bit_cnt_nxt = 3'd0;
              w_state_nxt   = RDAT;
            end else begin
              w_state_nxt = IGNORE;
            end
          end
        end
        IDLE, IGNORE: begin
        end
        default: begin
          w_state_nxt  = IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_ack_ph  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_ptr     <= 8'h00;
      r_rw      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ack_ph  <= w_ack_ph_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rw      <= w_rw_nxt;
      wr_stb    <= w_wr_en;
      if (w_wr_en) begin
        wr_addr <= r_ptr;
        wr_data <= w_byte;
      end
    end
  end

  // Peek reads the pre-write contents when an I2C write lands in the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) r_regs[i] <= 8'h00;
      host_data <= 8'h00;
    end else begin
      if (w_wr_en) r_regs[r_ptr] <= w_byte;
      host_data <= r_regs[host_addr];
    end
  end

endmodule
`default_nettype wire
